// File: rtl/ram_dump_reader.sv
// ram_dump_reader: streams a window of core-side RAM back to the host one byte per host read.
// Sits between the host download handshake (dl_*) and a shared memory port (mem_*) that is
// arbitrated against the Z80 through mem_gnt.
// Optional feature: define RAM_DUMP_CSUM_EN to append a two's-complement checksum byte so that
// all delivered bytes of a session sum to zero mod 256.
module ram_dump_reader #(
  parameter int unsigned ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              dl_rd,
  output logic [7:0]        dl_din,
  output logic              dl_wait,
  output logic [ADDR_W:0]   dl_addr,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic [7:0]        mem_q
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StLat,
    StReady,
`ifdef RAM_DUMP_CSUM_EN
    StFin,
    StCsum
`else
    StFin
`endif
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   offset_q, offset_d;
  logic [ADDR_W:0]   offset_inc;
  logic [7:0]        dl_din_q, dl_din_d;
  logic              dl_wait_q, dl_wait_d;
  logic [ADDR_W:0]   dl_addr_q, dl_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
`ifdef RAM_DUMP_CSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif

  // State and output registers; reset aborts any session without a done pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      base_q     <= '0;
      len_q      <= '0;
      offset_q   <= '0;
      dl_din_q   <= '0;
      dl_wait_q  <= 1'b0;
      dl_addr_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mem_addr_q <= '0;
`ifdef RAM_DUMP_CSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      len_q      <= len_d;
      offset_q   <= offset_d;
      dl_din_q   <= dl_din_d;
      dl_wait_q  <= dl_wait_d;
      dl_addr_q  <= dl_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mem_addr_q <= mem_addr_d;
`ifdef RAM_DUMP_CSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  // Next-state logic: request, wait one latency cycle, present byte, prefetch on consume.
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    offset_d   = offset_q;
    dl_din_d   = dl_din_q;
    dl_wait_d  = dl_wait_q;
    dl_addr_d  = dl_addr_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    mem_addr_d = mem_addr_q;
`ifdef RAM_DUMP_CSUM_EN
    sum_d      = sum_q;
`endif
    // offset < length <= 2^ADDR_W, so the increment never overflows ADDR_W+1 bits.
    offset_inc = offset_q + 1'b1;

    case (state_q)
      StIdle: begin
        // start has priority over dl_rd; dl_rd alone does nothing here.
        if (start) begin
          if (length != '0) begin
            base_d     = base_addr;
            len_d      = length;
            offset_d   = '0;
            busy_d     = 1'b1;
            dl_wait_d  = 1'b1;
            mem_addr_d = base_addr;
`ifdef RAM_DUMP_CSUM_EN
            sum_d      = '0;
`endif
            state_d    = StReq;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      StReq: begin
        // Address is held stable for as long as the arbiter stalls us.
        if (mem_gnt) begin
          state_d = StLat;
        end
      end

      StLat: begin
        dl_din_d  = mem_q;
        dl_wait_d = 1'b0;
        dl_addr_d = offset_q;
`ifdef RAM_DUMP_CSUM_EN
        sum_d     = sum_q + mem_q;
`endif
        state_d   = StReady;
      end

      StReady: begin
        if (dl_rd) begin
          if (offset_inc == len_q) begin
`ifdef RAM_DUMP_CSUM_EN
            // Negated running sum makes the whole delivered stream sum to zero.
            dl_din_d  = 8'd0 - sum_q;
            dl_addr_d = len_q;
            state_d   = StCsum;
`else
            done_d    = 1'b1;
            busy_d    = 1'b0;
            state_d   = StFin;
`endif
          end else begin
            offset_d   = offset_inc;
            dl_wait_d  = 1'b1;
            mem_addr_d = base_q + offset_inc[ADDR_W-1:0];
            state_d    = StReq;
          end
        end
      end

`ifdef RAM_DUMP_CSUM_EN
      StCsum: begin
        if (dl_rd) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StFin;
        end
      end
`endif

      StFin: begin
        // done is high during this cycle; dl_din/dl_addr keep their last values.
        dl_wait_d = 1'b0;
        state_d   = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // mem_req decodes straight from state so an async reset drops it immediately.
  always_comb begin
    mem_req = (state_q == StReq);
  end

  assign dl_din   = dl_din_q;
  assign dl_wait  = dl_wait_q;
  assign dl_addr  = dl_addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_ram_dump_reader.sv
// Testbench for ram_dump_reader: table-driven sessions, hand-written stall/reset sequences and
// randomized sessions checked against a window-of-memory reference model.
module tb_ram_dump_reader;

  localparam int AW = 15;
  localparam int MEM_SIZE = 1 << AW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          dl_rd = 1'b0;
  logic [7:0]    dl_din;
  logic          dl_wait;
  logic [AW:0]   dl_addr;
  logic          busy;
  logic          done;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt = 1'b1;
  logic [7:0]    mem_q = '0;

  ram_dump_reader #(.ADDR_W(AW)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .base_addr(base_addr),
    .length   (length),
    .dl_rd    (dl_rd),
    .dl_din   (dl_din),
    .dl_wait  (dl_wait),
    .dl_addr  (dl_addr),
    .busy     (busy),
    .done     (done),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_gnt  (mem_gnt),
    .mem_q    (mem_q)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]    mem [MEM_SIZE];
  logic [AW-1:0] gnt_addrs [$];
  int            done_cnt = 0;
  int            unstable = 0;
  int            gnt_mode = 1;  // 0 low, 1 high, 2 random
  logic          prev_req = 1'b0;
  logic          prev_gnt = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  // Memory model: data valid the cycle after a granted request.
  always @(posedge clk) begin
    if (mem_req && mem_gnt) mem_q <= mem[mem_addr];
  end

  // Monitors: granted addresses, done pulses, address stability while stalled.
  always @(posedge clk) begin
    if (reset_n && mem_req && mem_gnt) gnt_addrs.push_back(mem_addr);
    if (done) done_cnt <= done_cnt + 1;
    if (prev_req && !prev_gnt && mem_req && mem_addr != prev_addr) unstable <= unstable + 1;
    prev_req  <= mem_req & reset_n;
    prev_gnt  <= mem_gnt;
    prev_addr <= mem_addr;
  end

  // Arbiter model.
  always @(negedge clk) begin
    case (gnt_mode)
      0:       mem_gnt = 1'b0;
      1:       mem_gnt = 1'b1;
      default: mem_gnt = 1'($urandom_range(1, 0));
    endcase
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_gnt(input int mode);
    @(posedge clk);
    #1 gnt_mode = mode;
    @(negedge clk);
    @(negedge clk);
  endtask

  // One complete session; expected bytes come from the memory window (+ checksum).
  task automatic run_dump(input logic [AW-1:0] b, input logic [AW:0] len, input int gap_max,
                          input bit poke, output int n_req, output logic [AW-1:0] last_req,
                          output int last_byte);
    int g0, d0, n_bytes, waited, gap;
    logic [7:0] exp_b;
    logic [7:0] sum;
    g0 = gnt_addrs.size();
    d0 = done_cnt;
    last_byte = -1;
    @(negedge clk);
    start = 1'b1; base_addr = b; length = len;
    @(negedge clk);
    start = 1'b0;
    if (len == 0) begin
      check("zero_len_done", done, 1);
      check("zero_len_busy", busy, 0);
      check("zero_len_req", mem_req, 0);
    end else begin
      if (poke) begin
        check("poke_wait_high", dl_wait, 1);
        start = 1'b1; base_addr = ~b; length = len + 1'b1; dl_rd = 1'b1;
        @(negedge clk);
        start = 1'b0; dl_rd = 1'b0;
      end
      n_bytes = int'(len);
`ifdef RAM_DUMP_CSUM_EN
      n_bytes++;
`endif
      sum = 8'd0;
      for (int i = 0; i < n_bytes; i++) begin
        waited = 0;
        while (!(busy && !dl_wait) && waited < 200) begin
          @(negedge clk);
          waited++;
        end
        if (waited >= 200) begin
          check("byte_valid_timeout", 0, 1);
          return;
        end
        if (i < int'(len)) exp_b = mem[(int'(b) + i) % MEM_SIZE];
        else exp_b = 8'd0 - sum;
        sum = sum + exp_b;
        check("dl_din", dl_din, exp_b);
        check("dl_addr", dl_addr, i);
        gap = $urandom_range(gap_max, 0);
        if (gap > 0) begin
          repeat (gap) @(negedge clk);
          check("dl_din_hold", dl_din, exp_b);
        end
        last_byte = int'(dl_din);
        dl_rd = 1'b1;
        @(negedge clk);
        dl_rd = 1'b0;
      end
      waited = 0;
      while (!done && waited < 10) begin
        @(negedge clk);
        waited++;
      end
      check("done_seen", done, 1);
      check("busy_at_done", busy, 0);
      check("dl_wait_at_done", dl_wait, 0);
    end
    repeat (3) @(negedge clk);
    check("done_pulses", done_cnt - d0, 1);
    n_req = gnt_addrs.size() - g0;
    check("req_count", n_req, len);
    for (int i = 0; i < n_req && i < int'(len); i++)
      check("req_addr", gnt_addrs[g0 + i], (int'(b) + i) % MEM_SIZE);
    last_req = (n_req > 0) ? gnt_addrs[gnt_addrs.size() - 1] : '0;
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   len;
    int            gap;
    bit            poke;
    int            exp_reqs;
    logic [AW-1:0] exp_last_req;
    int            exp_last_byte;  // -1: not compared
  } vec_t;

  vec_t vecs [5];

  initial begin
    int n_req, last_byte, d0, waited;
    logic [AW-1:0] last_req;

    for (int a = 0; a < MEM_SIZE; a++) mem[a] = 8'($urandom);
    for (int a = 0; a < 4; a++) mem[16'h0100 + a] = 8'(8'h10 + a);
    mem[16'h0400] = 8'h01; mem[16'h0401] = 8'h02; mem[16'h0402] = 8'hFF;

    vecs[0] = '{base: 15'h0100, len: 16'd4, gap: 0, poke: 1'b0, exp_reqs: 4,
`ifdef RAM_DUMP_CSUM_EN
                exp_last_req: 15'h0103, exp_last_byte: 32'hBA};
`else
                exp_last_req: 15'h0103, exp_last_byte: 32'h13};
`endif
    vecs[1] = '{base: 15'h7FFF, len: 16'd3, gap: 1, poke: 1'b0, exp_reqs: 3,
                exp_last_req: 15'h0001, exp_last_byte: -1};
    vecs[2] = '{base: 15'h0050, len: 16'd0, gap: 0, poke: 1'b0, exp_reqs: 0,
                exp_last_req: 15'h0000, exp_last_byte: -1};
    vecs[3] = '{base: 15'h0400, len: 16'd3, gap: 2, poke: 1'b1, exp_reqs: 3,
`ifdef RAM_DUMP_CSUM_EN
                exp_last_req: 15'h0402, exp_last_byte: 32'hFE};
`else
                exp_last_req: 15'h0402, exp_last_byte: 32'hFF};
`endif
    vecs[4] = '{base: 15'h7FFF, len: 16'd2, gap: 0, poke: 1'b0, exp_reqs: 2,
                exp_last_req: 15'h0000, exp_last_byte: -1};

    // Reset state.
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_dl_din", dl_din, 0);
    check("rst_dl_wait", dl_wait, 0);
    check("rst_dl_addr", dl_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_mem_addr", mem_addr, 0);

    // dl_rd in IDLE is ignored.
    dl_rd = 1'b1;
    @(negedge clk);
    dl_rd = 1'b0;
    @(negedge clk);
    check("idle_rd_busy", busy, 0);
    check("idle_rd_req", mem_req, 0);
    check("idle_rd_done", done, 0);

    // Table-driven sessions, grant tied high.
    for (int v = 0; v < 5; v++) begin
      run_dump(vecs[v].base, vecs[v].len, vecs[v].gap, vecs[v].poke, n_req, last_req, last_byte);
      check("vec_reqs", n_req, vecs[v].exp_reqs);
      check("vec_last_req", last_req, vecs[v].exp_last_req);
      if (vecs[v].exp_last_byte >= 0) check("vec_last_byte", last_byte, vecs[v].exp_last_byte);
    end

    // Stall: grant low for 5 cycles after start, address held, dl_wait falls 2 edges later.
    set_gnt(0);
    d0 = done_cnt;
    start = 1'b1; base_addr = 15'h0200; length = 16'd1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check("stall_req", mem_req, 1);
      check("stall_addr", mem_addr, 15'h0200);
      check("stall_wait", dl_wait, 1);
      @(negedge clk);
    end
    @(posedge clk);
    #1 gnt_mode = 1;
    @(negedge clk);
    @(negedge clk);
    check("stall_lat_wait", dl_wait, 1);
    check("stall_lat_req", mem_req, 0);
    @(negedge clk);
    check("stall_ready_wait", dl_wait, 0);
    check("stall_ready_din", dl_din, mem[16'h0200]);
    check("stall_ready_addr", dl_addr, 0);
    dl_rd = 1'b1;
    @(negedge clk);
    dl_rd = 1'b0;
`ifdef RAM_DUMP_CSUM_EN
    check("stall_csum", dl_din, 8'd0 - mem[16'h0200]);
    dl_rd = 1'b1;
    @(negedge clk);
    dl_rd = 1'b0;
`endif
    check("stall_done", done, 1);
    repeat (2) @(negedge clk);
    check("stall_done_pulses", done_cnt - d0, 1);

    // Reset in REQ of the second byte: immediate abort, no done.
    d0 = done_cnt;
    start = 1'b1; base_addr = 15'h0300; length = 16'd4;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (!(busy && !dl_wait) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("rst_mid_first_byte", dl_din, mem[16'h0300]);
    dl_rd = 1'b1;
    @(negedge clk);
    dl_rd = 1'b0;
    check("rst_mid_in_req", mem_req, 1);
    check("rst_mid_req_addr", mem_addr, 15'h0301);
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_req_drop", mem_req, 0);
    check("rst_mid_busy_drop", busy, 0);
    check("rst_mid_wait_drop", dl_wait, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_mid_no_done", done_cnt - d0, 0);
    run_dump(15'h0300, 16'd4, 0, 1'b0, n_req, last_req, last_byte);
    check("rst_mid_restart_last_req", last_req, 15'h0303);

    // Randomized sessions with a random arbiter.
    set_gnt(2);
    for (int s = 0; s < 30; s++) begin
      logic [AW-1:0] b;
      logic [AW:0]   len;
      b = ($urandom_range(3, 0) == 0) ? AW'(15'h7FF8 + $urandom_range(7, 0)) : AW'($urandom);
      len = (AW + 1)'($urandom_range(10, 0));
      run_dump(b, len, $urandom_range(2, 0), 1'($urandom_range(1, 0)), n_req, last_req,
               last_byte);
    end

    check("addr_stable_while_stalled", unstable, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ram_dump_reader.md
Name: ram_dump_reader

Overview:
- Streams a window of core-side RAM (ext RAM, main RAM or a VRAM plane) back to the host, one byte per host read.
- It is the read direction of the cart/RAM upload path, used for save-RAM and VRAM dumps.
- It sits between the host download handshake and a shared memory port, arbitrated against the Z80 through a grant input.

Parameters:
- ADDR_W, 15, memory address width. Dump window size is up to 2^ADDR_W bytes.

Ports:
- clk  in  1  system clock (clk_sys)
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse that begins a dump session
- base_addr  in  ADDR_W  first memory address, sampled on start
- length  in  ADDR_W+1  byte count, sampled on start; 0 is legal
- dl_rd  in  1  host consumes the current byte (one-cycle pulse)
- dl_din  out  8  current byte presented to the host
- dl_wait  out  1  high while dl_din is not valid
- dl_addr  out  ADDR_W+1  offset of the byte on dl_din
- busy  out  1  session active
- done  out  1  one-cycle pulse at session end
- mem_req  out  1  read request to the shared memory port
- mem_addr  out  ADDR_W  read address
- mem_gnt  in  1  port free for the block this cycle
- mem_q  in  8  read data, valid one cycle after a granted request

Behaviour:
- Reset (async assert, sync release): state IDLE; dl_din=0, dl_wait=0, dl_addr=0, busy=0, done=0, mem_req=0, mem_addr=0, checksum=0. Reset mid-session aborts immediately: mem_req drops asynchronously and no done pulse is issued.
- IDLE:
  - On start with length!=0: latch base/length, offset=0, sum=0, busy=1, dl_wait=1, go REQ.
  - On start with length==0: done=1 for one cycle, busy stays 0, no mem_req.
- REQ: mem_req=1, mem_addr=(base+offset) mod 2^ADDR_W, held stable. Edge with mem_gnt=1 goes to LAT; mem_gnt=0 stalls indefinitely.
- LAT: mem_req=0. Next edge captures mem_q into dl_din, adds it to sum (8-bit, wrapping), sets dl_wait=0 and dl_addr=offset, go READY.
- Latency: with mem_gnt tied high, dl_wait falls 3 edges after the start edge: IDLE to REQ, REQ to LAT, LAT to READY.
- READY: dl_din held.
  - On dl_rd: if offset+1==length, go FIN (or CSUM, see below). Otherwise offset++, dl_wait=1, go REQ (prefetch next byte).
- dl_rd while dl_wait=1 or in IDLE is ignored; no state change.
- start while busy=1 is ignored.
- FIN: done=1 for one cycle, busy=0, dl_wait=0, go IDLE. dl_din and dl_addr keep their last values.
- Address arithmetic: offset is ADDR_W+1 bits. mem_addr wraps modulo 2^ADDR_W, so base 0x7FFF with length 2 reads 0x7FFF then 0x0000.
- start and dl_rd in the same cycle in IDLE: start wins.

Optional Feature:
- Macro: RAM_DUMP_CSUM_EN.
- Defined: after the last data byte is consumed, go CSUM and present dl_din = (~sum)+1 (two's complement), dl_addr = length, dl_wait=0. The next dl_rd goes to FIN. The session delivers length+1 bytes, and the sum of all delivered bytes is 0 mod 256.
- Undefined: no CSUM state; FIN follows the last data byte; no checksum logic.

Test Plan:
- Basic: memory 0x10..0x13 at addr 0x0100, base=0x0100, length=4, mem_gnt=1, dl_rd one cycle after each dl_wait fall -> dl_din 0x10, 0x11, 0x12, 0x13 with dl_addr 0..3; one done pulse; mem_req asserted exactly 4 times.
- Latency and stall: mem_gnt=0 for 5 cycles after start -> mem_req held with mem_addr=base stable; dl_wait falls 2 edges after mem_gnt rises.
- Wrap: base=0x7FFF, length=3 -> mem_addr sequence 0x7FFF, 0x0000, 0x0001.
- Zero length and ignores: length=0 -> done pulses on the next edge, busy stays 0, no mem_req. dl_rd while dl_wait=1 -> no extra byte. start while busy -> ignored.
- Reset mid-dump: reset_n low in REQ of byte 2 -> mem_req=0 and busy=0 immediately, no done. A new start after release delivers from offset 0.
- RAM_DUMP_CSUM_EN: bytes 0x01, 0x02, 0xFF -> fourth byte 0xFE at dl_addr=3, then done.
